// File: rtl/wb_buf_bridge_if.sv
// Bus bundle for wb_buf_bridge: Wishbone slave side plus the request/response
// channel toward the downstream buffer.
interface wb_buf_bridge_if #(
  parameter int ADR_W = 8,
  parameter int DAT_W = 32
);
  logic [ADR_W-1:0]       WB_ADR_I;
  logic [DAT_W-1:0]       WB_DAT_I;
  logic                   WB_WE_I;
  logic                   WB_CYC_I;
  logic                   WB_STB_I;
  logic [DAT_W-1:0]       WB_DAT_O;
  logic                   WB_ACK_O;
  logic                   WB_ERR_O;
  logic                   BUF_STATUS;
  logic [ADR_W+DAT_W:0]   BUF_DATA_O;
  logic [ADR_W+DAT_W:0]   BUF_DATA_I;
  logic                   BUF_ACK;

  modport slave (
    input  WB_ADR_I, WB_DAT_I, WB_WE_I, WB_CYC_I, WB_STB_I, BUF_DATA_I, BUF_ACK,
    output WB_DAT_O, WB_ACK_O, WB_ERR_O, BUF_STATUS, BUF_DATA_O
  );

  modport master (
    output WB_ADR_I, WB_DAT_I, WB_WE_I, WB_CYC_I, WB_STB_I, BUF_DATA_I, BUF_ACK,
    input  WB_DAT_O, WB_ACK_O, WB_ERR_O, BUF_STATUS, BUF_DATA_O
  );
endinterface

// File: rtl/wb_buf_bridge.sv
// Wishbone slave that forwards each transfer as a packed request to a buffer,
// then terminates with ACK on buffer completion or ERR after a timeout.
module wb_buf_bridge #(
  parameter int ADR_W   = 8,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             WB_CLK_I,
  input  logic             WB_RST_I,
  wb_buf_bridge_if.slave   bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int BUF_W = ADR_W + DAT_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DAT_W-1:0]   dat_q;
  logic               ack_q;
  logic               err_q;
  logic               status_q;
  logic [BUF_W-1:0]   buf_data_q;

  assign bus.WB_DAT_O   = dat_q;
  assign bus.WB_ACK_O   = ack_q;
  assign bus.WB_ERR_O   = err_q;
  assign bus.BUF_STATUS = status_q;
  assign bus.BUF_DATA_O = buf_data_q;

  // Within WAIT, a master abort beats buffer completion, which beats timeout.
  always_ff @(posedge WB_CLK_I) begin
    if (WB_RST_I) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dat_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      status_q   <= 1'b0;
      buf_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.WB_CYC_I && bus.WB_STB_I) begin
            buf_data_q <= {bus.WB_ADR_I, bus.WB_DAT_I, ~bus.WB_WE_I};
            status_q   <= 1'b1;
            cnt        <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.WB_CYC_I) begin
            status_q   <= 1'b0;
            buf_data_q <= '0;
            state      <= ST_IDLE;
          end else if (bus.BUF_ACK) begin
            ack_q      <= 1'b1;
            dat_q      <= buf_data_q[0] ? bus.BUF_DATA_I[DAT_W:1] : '0;
            status_q   <= 1'b0;
            buf_data_q <= '0;
            state      <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            dat_q      <= '0;
            status_q   <= 1'b0;
            buf_data_q <= '0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_buf_bridge.sv
// Directed bench for wb_buf_bridge: default, short-timeout and narrow-bus
// instances driven through one linear sequence of steps.
module tb_wb_buf_bridge;
  logic WB_CLK_I = 1'b0;
  logic WB_RST_I = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 WB_CLK_I = ~WB_CLK_I;

  wb_buf_bridge_if #(.ADR_W(8),  .DAT_W(32)) bus0 ();
  wb_buf_bridge_if #(.ADR_W(8),  .DAT_W(32)) bus1 ();
  wb_buf_bridge_if #(.ADR_W(16), .DAT_W(8))  bus2 ();

  wb_buf_bridge #(.ADR_W(8), .DAT_W(32), .TIMEOUT(255)) dut0 (
    .WB_CLK_I(WB_CLK_I), .WB_RST_I(WB_RST_I), .bus(bus0));
  wb_buf_bridge #(.ADR_W(8), .DAT_W(32), .TIMEOUT(4)) dut1 (
    .WB_CLK_I(WB_CLK_I), .WB_RST_I(WB_RST_I), .bus(bus1));
  wb_buf_bridge #(.ADR_W(16), .DAT_W(8), .TIMEOUT(255)) dut2 (
    .WB_CLK_I(WB_CLK_I), .WB_RST_I(WB_RST_I), .bus(bus2));

  // Advance n rising edges; inputs are driven and outputs sampled 1ns later.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge WB_CLK_I);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  initial begin
    {bus0.WB_ADR_I, bus0.WB_DAT_I, bus0.WB_WE_I, bus0.WB_CYC_I, bus0.WB_STB_I} = '0;
    {bus1.WB_ADR_I, bus1.WB_DAT_I, bus1.WB_WE_I, bus1.WB_CYC_I, bus1.WB_STB_I} = '0;
    {bus2.WB_ADR_I, bus2.WB_DAT_I, bus2.WB_WE_I, bus2.WB_CYC_I, bus2.WB_STB_I} = '0;
    bus0.BUF_DATA_I = '0; bus0.BUF_ACK = 1'b0;
    bus1.BUF_DATA_I = '0; bus1.BUF_ACK = 1'b0;
    bus2.BUF_DATA_I = '0; bus2.BUF_ACK = 1'b0;

    WB_RST_I = 1'b1;
    applyStimulus(2);
    WB_RST_I = 1'b0;
    checkOutput("rst_ack",    64'(bus0.WB_ACK_O),   64'd0);
    checkOutput("rst_err",    64'(bus0.WB_ERR_O),   64'd0);
    checkOutput("rst_dat",    64'(bus0.WB_DAT_O),   64'd0);
    checkOutput("rst_status", 64'(bus0.BUF_STATUS), 64'd0);
    checkOutput("rst_bufdat", 64'(bus0.BUF_DATA_O), 64'd0);
    checkOutput("rst_bufdat2", 64'(bus2.BUF_DATA_O), 64'd0);

    // STB without CYC and a stray BUF_ACK in IDLE must do nothing.
    bus0.WB_STB_I = 1'b1; bus0.BUF_ACK = 1'b1;
    applyStimulus(1);
    checkOutput("nocyc_status", 64'(bus0.BUF_STATUS), 64'd0);
    checkOutput("idle_ack",     64'(bus0.WB_ACK_O),   64'd0);
    bus0.WB_STB_I = 1'b0; bus0.BUF_ACK = 1'b0;

    // Read on the default instance.
    bus0.WB_ADR_I = 8'h34; bus0.WB_DAT_I = 32'h11111111; bus0.WB_WE_I = 1'b0;
    bus0.WB_CYC_I = 1'b1;  bus0.WB_STB_I = 1'b1;
    applyStimulus(1);
    checkOutput("rd_status", 64'(bus0.BUF_STATUS), 64'd1);
    checkOutput("rd_pack",   64'(bus0.BUF_DATA_O), 64'({8'h34, 32'h11111111, 1'b1}));
    bus0.BUF_DATA_I = {8'h00, 32'hCAFEF00D, 1'b0}; bus0.BUF_ACK = 1'b1;
    applyStimulus(1);
    checkOutput("rd_ack",    64'(bus0.WB_ACK_O),   64'd1);
    checkOutput("rd_dat",    64'(bus0.WB_DAT_O),   64'hCAFEF00D);
    checkOutput("rd_status0", 64'(bus0.BUF_STATUS), 64'd0);
    checkOutput("rd_bufdat0", 64'(bus0.BUF_DATA_O), 64'd0);
    bus0.BUF_ACK = 1'b0; bus0.WB_CYC_I = 1'b0; bus0.WB_STB_I = 1'b0;
    applyStimulus(1);
    checkOutput("rd_ack_pulse", 64'(bus0.WB_ACK_O), 64'd0);

    // Write with BUF_ACK arriving three cycles after the strobe.
    bus0.WB_ADR_I = 8'h12; bus0.WB_DAT_I = 32'hDEADBEEF; bus0.WB_WE_I = 1'b1;
    bus0.WB_CYC_I = 1'b1;  bus0.WB_STB_I = 1'b1;
    applyStimulus(1);
    checkOutput("wr_pack", 64'(bus0.BUF_DATA_O), 64'({8'h12, 32'hDEADBEEF, 1'b0}));
    bus0.WB_ADR_I = 8'hFF; bus0.WB_DAT_I = 32'h0;
    applyStimulus(2);
    checkOutput("wr_hold",   64'(bus0.BUF_DATA_O), 64'({8'h12, 32'hDEADBEEF, 1'b0}));
    checkOutput("wr_status", 64'(bus0.BUF_STATUS), 64'd1);
    checkOutput("wr_noack",  64'(bus0.WB_ACK_O),   64'd0);
    bus0.BUF_ACK = 1'b1;
    applyStimulus(1);
    checkOutput("wr_ack", 64'(bus0.WB_ACK_O), 64'd1);
    checkOutput("wr_dat", 64'(bus0.WB_DAT_O), 64'd0);
    checkOutput("wr_err", 64'(bus0.WB_ERR_O), 64'd0);
    bus0.BUF_ACK = 1'b0; bus0.WB_CYC_I = 1'b0; bus0.WB_STB_I = 1'b0;
    applyStimulus(1);
    checkOutput("wr_ack_pulse", 64'(bus0.WB_ACK_O), 64'd0);

    // Timeout with TIMEOUT=4: ERR after the fourth WAIT cycle.
    bus1.WB_ADR_I = 8'h56; bus1.WB_DAT_I = 32'h01020304; bus1.WB_WE_I = 1'b1;
    bus1.WB_CYC_I = 1'b1;  bus1.WB_STB_I = 1'b1;
    applyStimulus(4);
    checkOutput("to_pending", 64'(bus1.BUF_STATUS), 64'd1);
    checkOutput("to_noerr",   64'(bus1.WB_ERR_O),   64'd0);
    applyStimulus(1);
    checkOutput("to_err",    64'(bus1.WB_ERR_O),   64'd1);
    checkOutput("to_ack",    64'(bus1.WB_ACK_O),   64'd0);
    checkOutput("to_status", 64'(bus1.BUF_STATUS), 64'd0);
    checkOutput("to_bufdat", 64'(bus1.BUF_DATA_O), 64'd0);
    bus1.WB_CYC_I = 1'b0; bus1.WB_STB_I = 1'b0;
    applyStimulus(1);
    checkOutput("to_err_pulse", 64'(bus1.WB_ERR_O), 64'd0);

    // BUF_ACK on the expiry cycle: ACK wins.
    bus1.WB_CYC_I = 1'b1; bus1.WB_STB_I = 1'b1;
    applyStimulus(4);
    bus1.BUF_ACK = 1'b1;
    applyStimulus(1);
    checkOutput("race_ack", 64'(bus1.WB_ACK_O), 64'd1);
    checkOutput("race_err", 64'(bus1.WB_ERR_O), 64'd0);
    bus1.BUF_ACK = 1'b0; bus1.WB_CYC_I = 1'b0; bus1.WB_STB_I = 1'b0;
    applyStimulus(1);

    // Master abort coincident with BUF_ACK.
    bus1.WB_CYC_I = 1'b1; bus1.WB_STB_I = 1'b1;
    applyStimulus(1);
    bus1.WB_CYC_I = 1'b0; bus1.WB_STB_I = 1'b0; bus1.BUF_ACK = 1'b1;
    applyStimulus(1);
    checkOutput("abort_ack",    64'(bus1.WB_ACK_O),   64'd0);
    checkOutput("abort_err",    64'(bus1.WB_ERR_O),   64'd0);
    checkOutput("abort_status", 64'(bus1.BUF_STATUS), 64'd0);
    applyStimulus(1);
    checkOutput("abort_idle_ack", 64'(bus1.WB_ACK_O), 64'd0);
    bus1.BUF_ACK = 1'b0;

    // Reset pulsed mid-transfer, then a late BUF_ACK.
    bus1.WB_CYC_I = 1'b1; bus1.WB_STB_I = 1'b1;
    applyStimulus(1);
    WB_RST_I = 1'b1;
    applyStimulus(1);
    checkOutput("rstw_status", 64'(bus1.BUF_STATUS), 64'd0);
    checkOutput("rstw_bufdat", 64'(bus1.BUF_DATA_O), 64'd0);
    checkOutput("rstw_ack",    64'(bus1.WB_ACK_O),   64'd0);
    WB_RST_I = 1'b0; bus1.WB_CYC_I = 1'b0; bus1.WB_STB_I = 1'b0; bus1.BUF_ACK = 1'b1;
    applyStimulus(1);
    checkOutput("rstw_late_ack", 64'(bus1.WB_ACK_O), 64'd0);
    bus1.BUF_ACK = 1'b0;

    // Narrow bus, back-to-back reads with BUF_ACK held high throughout.
    bus2.WB_ADR_I = 16'hA5C3; bus2.WB_DAT_I = 8'h5A; bus2.WB_WE_I = 1'b0;
    bus2.WB_CYC_I = 1'b1; bus2.WB_STB_I = 1'b1;
    bus2.BUF_DATA_I = {16'h0000, 8'h3C, 1'b0}; bus2.BUF_ACK = 1'b1;
    applyStimulus(1);
    checkOutput("b2b_pack1", 64'(bus2.BUF_DATA_O), 64'({16'hA5C3, 8'h5A, 1'b1}));
    applyStimulus(1);
    checkOutput("b2b_ack1", 64'(bus2.WB_ACK_O), 64'd1);
    checkOutput("b2b_dat1", 64'(bus2.WB_DAT_O), 64'h3C);
    bus2.WB_ADR_I = 16'h1234; bus2.WB_DAT_I = 8'h00;
    bus2.BUF_DATA_I = {16'hFFFF, 8'hC3, 1'b1};
    applyStimulus(1);
    checkOutput("b2b_done_ack",    64'(bus2.WB_ACK_O),   64'd0);
    checkOutput("b2b_done_status", 64'(bus2.BUF_STATUS), 64'd0);
    applyStimulus(1);
    checkOutput("b2b_pack2", 64'(bus2.BUF_DATA_O), 64'({16'h1234, 8'h00, 1'b1}));
    applyStimulus(1);
    checkOutput("b2b_ack2", 64'(bus2.WB_ACK_O), 64'd1);
    checkOutput("b2b_dat2", 64'(bus2.WB_DAT_O), 64'hC3);
    bus2.WB_CYC_I = 1'b0; bus2.WB_STB_I = 1'b0; bus2.BUF_ACK = 1'b0;
    applyStimulus(1);
    checkOutput("b2b_ack2_pulse", 64'(bus2.WB_ACK_O), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
